// File: rtl/sipo_rx_ctrl.sv
// sipo_rx_ctrl: serial-in / parallel-out receiver with a one-word output register.
// A frame is a start bit (si=1) followed by N data bits, MSB first.
// Optional build macro SIPO_PARITY_EN appends an even-parity bit after the data bits.
// Completed words are handed to the consumer with a po_valid/po_ready handshake.
// A word completed while the previous one is still pending is dropped and flagged
// on the sticky overrun output.
module sipo_rx_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         si,
  output logic [N-1:0] po,
  output logic         po_valid,
  input  logic         po_ready,
  output logic         busy,
  output logic         overrun,
  output logic         parity_err
);

  localparam int CW = $clog2(N + 1);

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PAR = 2'd2} state_t;

  // Even parity: the parity bit equals the XOR of all data bits.
  function automatic logic even_par(input logic [N-1:0] w);
    return ^w;
  endfunction
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1} state_t;
`endif

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [N-1:0]    sreg_r;
  logic [N-1:0]    po_r;
  logic            po_valid_r;
  logic            busy_r;
  logic            overrun_r;
  logic            parity_err_r;

  logic [N-1:0]    shift_s;
  logic            last_bit_s;
  logic            done_s;
  logic            perr_s;
  logic [N-1:0]    word_s;
  logic            accept_s;
  logic            drop_s;

  assign shift_s    = {sreg_r[N-2:0], si};
  assign last_bit_s = (state_r == DATA) && (cnt_r == CW'(N - 1));

  // Decide whether a word completes on this edge and whether it is kept or dropped.
  always_comb begin
    done_s   = 1'b0;
    perr_s   = 1'b0;
    word_s   = shift_s;
`ifdef SIPO_PARITY_EN
    word_s   = sreg_r;
    if (state_r == PAR) begin
      if (si == even_par(sreg_r)) begin
        done_s = 1'b1;
        perr_s = 1'b0;
      end else begin
        done_s = 1'b0;
        perr_s = 1'b1;
      end
    end else begin
      done_s = 1'b0;
      perr_s = 1'b0;
    end
`else
    done_s   = last_bit_s;
    perr_s   = 1'b0;
`endif
    // The output register is free if empty or being consumed on this same edge.
    accept_s = done_s && (!po_valid_r || po_ready);
    drop_s   = done_s && po_valid_r && !po_ready;
  end

  // Receive FSM, shift register, output word/handshake and status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      sreg_r       <= '0;
      po_r         <= '0;
      po_valid_r   <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      if (accept_s) begin
        po_r       <= word_s;
        po_valid_r <= 1'b1;
      end else if (po_valid_r && po_ready) begin
        po_valid_r <= 1'b0;
      end else begin
        po_valid_r <= po_valid_r;
      end

      if (drop_s) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end

      parity_err_r <= perr_s;

      case (state_r)
        IDLE: begin
          if (si) begin
            state_r <= DATA;
            busy_r  <= 1'b1;
            cnt_r   <= '0;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        DATA: begin
          sreg_r <= shift_s;
          cnt_r  <= cnt_r + CW'(1);
          if (last_bit_s) begin
`ifdef SIPO_PARITY_EN
            state_r <= PAR;
            busy_r  <= 1'b1;
`else
            state_r <= IDLE;
            busy_r  <= 1'b0;
`endif
          end else begin
            state_r <= DATA;
            busy_r  <= 1'b1;
          end
        end
`ifdef SIPO_PARITY_EN
        PAR: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
`endif
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign po         = po_r;
  assign po_valid   = po_valid_r;
  assign busy       = busy_r;
  assign overrun    = overrun_r;
  assign parity_err = parity_err_r;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Self-checking bench for sipo_rx_ctrl (N=4). Inputs change on the falling edge;
// outputs are compared on the falling edge. Words expected to reach the consumer
// are queued when their frame is driven and popped when a handshake is observed.
module tb_sipo_rx_ctrl;

  localparam int N = 4;
`ifdef SIPO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         si = 1'b0;
  logic         po_ready = 1'b0;
  logic [N-1:0] po;
  logic         po_valid;
  logic         busy;
  logic         overrun;
  logic         parity_err;

  int errors = 0;
  int checks = 0;
  logic [N-1:0] sb_q[$];
  logic [N-1:0] sb_exp;

  typedef struct {
    logic [N-1:0] d;
    logic [N-1:0] exp_po;
    logic         exp_valid;
    logic         exp_ovr;
  } vec_t;

  vec_t vecs[6];

  sipo_rx_ctrl #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .si         (si),
    .po         (po),
    .po_valid   (po_valid),
    .po_ready   (po_ready),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a handshake is due on the next rising edge.
  always begin
    @(negedge clk);
    #2;
    if (rst && po_valid && po_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got word %b expected none (t=%0t)", po, $time);
      end else begin
        sb_exp = sb_q.pop_front();
        chkw("sb_word", po, sb_exp);
      end
    end
  end

  // Drive one frame starting at the current falling edge; po_ready is set to
  // rdy_last together with the final bit so it is seen on the completing edge.
  task automatic frame(input logic [N-1:0] d, input logic bad_par, input logic rdy_last);
    si = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      @(negedge clk);
      si = d[i];
      if (i == 0 && !PAR_EN) po_ready = rdy_last;
    end
    if (PAR_EN) begin
      @(negedge clk);
      si = (^d) ^ bad_par;
      po_ready = rdy_last;
    end
  endtask

  // Consume the pending word with a single-cycle po_ready pulse.
  task automatic drain();
    po_ready = 1'b1;
    @(negedge clk);
    po_ready = 1'b0;
    chkb("drain_valid", po_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b1011, 4'b1011, 1'b1, 1'b0};
    vecs[1] = '{4'b0110, 4'b0110, 1'b1, 1'b0};
    vecs[2] = '{4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[3] = '{4'b1111, 4'b1111, 1'b1, 1'b0};
    vecs[4] = '{4'b1001, 4'b1001, 1'b1, 1'b0};
    vecs[5] = '{4'b0001, 4'b0001, 1'b1, 1'b0};

    // Reset state
    rst = 1'b0; si = 1'b0; po_ready = 1'b0;
    repeat (2) @(negedge clk);
    chkw("rst_po", po, 4'b0000);
    chkb("rst_valid", po_valid, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_ovr", overrun, 1'b0);
    chkb("rst_perr", parity_err, 1'b0);
    rst = 1'b1;

    // Idle line, po_ready toggling while nothing is pending
    for (int c = 0; c < 20; c++) begin
      po_ready = c[0];
      @(negedge clk);
      chkb("idle_busy", busy, 1'b0);
      chkb("idle_valid", po_valid, 1'b0);
      chkw("idle_po", po, 4'b0000);
    end
    po_ready = 1'b0;

    // Single frame, then a second one that must overrun
    sb_q.push_back(4'b1011);
    frame(4'b1011, 1'b0, 1'b0);
    @(negedge clk); si = 1'b0;
    chkw("f1_po", po, 4'b1011);
    chkb("f1_valid", po_valid, 1'b1);
    chkb("f1_busy", busy, 1'b0);
    chkb("f1_ovr", overrun, 1'b0);
    chkb("f1_perr", parity_err, 1'b0);
    frame(4'b0110, 1'b0, 1'b0);
    @(negedge clk); si = 1'b0;
    chkw("ovr_po", po, 4'b1011);
    chkb("ovr_valid", po_valid, 1'b1);
    chkb("ovr_flag", overrun, 1'b1);
    repeat (3) @(negedge clk);
    chkw("ovr_po_hold", po, 4'b1011);
    drain();
    chkb("ovr_sticky", overrun, 1'b1);

    // Reset clears the sticky flag
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chkb("rst2_ovr", overrun, 1'b0);
    chkb("rst2_valid", po_valid, 1'b0);
    chkw("rst2_po", po, 4'b0000);

    // Completion and handshake on the same edge
    sb_q.push_back(4'b1011);
    frame(4'b1011, 1'b0, 1'b0);
    @(negedge clk); si = 1'b0;
    chkb("same_v1", po_valid, 1'b1);
    sb_q.push_back(4'b0110);
    frame(4'b0110, 1'b0, 1'b1);
    @(negedge clk); si = 1'b0; po_ready = 1'b0;
    chkw("same_po", po, 4'b0110);
    chkb("same_valid", po_valid, 1'b1);
    chkb("same_ovr", overrun, 1'b0);
    drain();

    // Reset in the middle of a frame
    si = 1'b1;
    @(negedge clk); si = 1'b1;
    @(negedge clk); si = 1'b0;
    chkb("mid_busy", busy, 1'b1);
    @(negedge clk); rst = 1'b0; si = 1'b0;
    @(negedge clk); rst = 1'b1;
    chkb("mid_rst_busy", busy, 1'b0);
    chkb("mid_rst_valid", po_valid, 1'b0);
    chkw("mid_rst_po", po, 4'b0000);
    sb_q.push_back(4'b0110);
    frame(4'b0110, 1'b0, 1'b0);
    @(negedge clk); si = 1'b0;
    chkw("after_rst_po", po, 4'b0110);
    chkb("after_rst_valid", po_valid, 1'b1);
    chkb("after_rst_ovr", overrun, 1'b0);
    drain();

    // Table: back-to-back frames with the consumer always ready
    po_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      sb_q.push_back(vecs[v].d);
      frame(vecs[v].d, 1'b0, 1'b1);
      @(negedge clk); si = 1'b0;
      chkw("tbl_po", po, vecs[v].exp_po);
      chkb("tbl_valid", po_valid, vecs[v].exp_valid);
      chkb("tbl_ovr", overrun, vecs[v].exp_ovr);
      chkb("tbl_busy", busy, 1'b0);
    end
    @(negedge clk);
    po_ready = 1'b0;
    chkb("tbl_end_valid", po_valid, 1'b0);

`ifdef SIPO_PARITY_EN
    // Bad parity drops the word and pulses parity_err
    frame(4'b1011, 1'b1, 1'b0);
    @(negedge clk); si = 1'b0;
    chkb("perr_pulse", parity_err, 1'b1);
    chkb("perr_valid", po_valid, 1'b0);
    @(negedge clk);
    chkb("perr_clear", parity_err, 1'b0);
    sb_q.push_back(4'b1011);
    frame(4'b1011, 1'b0, 1'b0);
    @(negedge clk); si = 1'b0;
    chkw("pok_po", po, 4'b1011);
    chkb("pok_valid", po_valid, 1'b1);
    chkb("pok_perr", parity_err, 1'b0);
    drain();
`endif

    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending words expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sipo_rx_ctrl.md
SIPO_RX_CTRL -- requirements
Module: sipo_rx_ctrl

Interface
REQ-001 Parameter: N, 4, data word width in bits (N >= 2).
REQ-002 Port: clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 Port: rst  input  1  synchronous, active-low reset.
REQ-004 Port: si  input  1  serial input, sampled every rising clk edge.
REQ-005 Port: po  output  N  parallel output word, registered.
REQ-006 Port: po_valid  output  1  po holds an unconsumed word.
REQ-007 Port: po_ready  input  1  consumer accepts po this cycle.
REQ-008 Port: busy  output  1  frame reception in progress (FSM not IDLE).
REQ-009 Port: overrun  output  1  sticky flag: a completed word was dropped.
REQ-010 Port: parity_err  output  1  one-cycle pulse: parity check failed.

Function
REQ-011 The FSM SHALL have states IDLE, DATA and PAR (PAR only when parity is compiled in).
REQ-012 In IDLE, si=1 sampled on an edge SHALL be taken as the start bit: move to DATA, clear bit counter to 0.
REQ-013 In IDLE, si=0 SHALL keep the FSM in IDLE with no register changes.
REQ-014 In DATA, each edge SHALL shift si into an internal N-bit register MSB-first (sreg <= {sreg[N-2:0], si}) and increment the counter.
REQ-015 On the edge sampling data bit N, the FSM SHALL go to PAR if parity is enabled, else to IDLE and complete the word.
REQ-016 Word completion SHALL load po and set po_valid on that same edge (po_valid visible the cycle after the last data bit).
REQ-017 A handshake SHALL occur on an edge where po_valid=1 and po_ready=1; po_valid then clears unless a word completes on the same edge.
REQ-018 Word completion with po_valid=1 and po_ready=1 on the same edge SHALL load the new word, keep po_valid=1 and not set overrun.
REQ-019 Word completion with po_valid=1 and po_ready=0 SHALL drop the new word, keep po unchanged and set overrun.
REQ-020 overrun SHALL stay 1 until reset.
REQ-021 po SHALL remain stable while po_valid=1 and no handshake occurs.
REQ-022 After returning to IDLE, a start bit SHALL be accepted on the very next edge (back-to-back frames, N+1 cycles per frame without parity).
REQ-023 busy SHALL be 1 exactly when the FSM is in DATA or PAR.
REQ-024 po_ready while po_valid=0 SHALL have no effect.

Reset
REQ-025 On an edge with rst=0: FSM to IDLE, counter 0, internal shift register 0, po=0, po_valid=0, overrun=0, parity_err=0.
REQ-026 Reset mid-frame SHALL discard the partial frame; no completion or overrun is produced.
REQ-027 Reset SHALL take priority over every other event on the same edge.

Configuration
REQ-028 Macro SIPO_PARITY_EN SHALL compile in an even-parity bit following the N data bits.
REQ-029 With SIPO_PARITY_EN: in PAR the sampled bit SHALL be compared with XOR of sreg; match completes the word per REQ-016..019, then IDLE.
REQ-030 With SIPO_PARITY_EN: mismatch SHALL drop the word, leave po/po_valid/overrun unchanged, pulse parity_err for one cycle, then IDLE.
REQ-031 Without SIPO_PARITY_EN: no PAR state, frame is N+1 cycles, parity_err SHALL be tied 0.

Verification
REQ-032 N=4, rst then si=0 for 20 cycles -> busy=0, po_valid=0, po=0000 throughout.
REQ-033 Start bit then 1,0,1,1 (parity 1 if enabled), po_ready=0 -> po=1011, po_valid=1 after last bit edge, busy=0.
REQ-034 po_ready=0, two frames 1011 then 0110 -> po=1011, po_valid=1, overrun=1 after second frame.
REQ-035 po_valid=1 (1011), po_ready=1 on edge completing 0110 -> po=0110, po_valid=1, overrun=0.
REQ-036 rst=0 for one edge after 2 data bits -> busy=0, po_valid=0; next frame 0110 -> po=0110.
REQ-037 SIPO_PARITY_EN, frame 1011 parity 0 -> parity_err one-cycle pulse, po_valid=0; parity 1 -> po=1011, po_valid=1.
